// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes a WIDTH-bit add, one bit per
// clock, LSB first. The cell's carry-out is registered back into its carry-in.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; clears all state
//   start  - begin an add (sampled only in IDLE)
//   a, b   - operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when sum/cout have just been updated
//   sum    - registered result a+b+cin mod 2^WIDTH
//   cout   - registered final carry-out
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds only the upper WIDTH-1 bits of the partial sum; the newest bit
    // comes straight from the cell, so the bit that would fall off is never stored.
    logic [WIDTH-2:0] psum;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             p, g, s, cell_cout;
    logic             last_bit;
    logic [WIDTH-1:0] psum_next;

    // Full-adder cell
    always_comb begin
        p         = a_sr[0] ^ b_sr[0];
        g         = a_sr[0] & b_sr[0];
        s         = p ^ carry;
        cell_cout = g | (p & carry);
        psum_next = {s, psum};
        last_bit  = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= psum_next[WIDTH-1:1];
                    carry <= cell_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= psum_next;
                        cout <= cell_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete add. Cycle k=1 is the first cycle after the accepting edge;
    // done must appear in cycle k=9 (WIDTH+1), busy must be high for 8 cycles.
    task automatic do_add(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic [7:0] es, input logic ec,
                          input logic [7:0] prev_sum, input logic check_hold,
                          input logic repulse);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_k   = 0;
        logic hold_bad = 1'b0;
        logic [7:0] sum_at_done = 8'h00;
        logic cout_at_done = 1'b0;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'hA5; b = 8'h3C; cin = ~tc;   // operand changes must not matter
        for (int k = 1; k <= 14; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k       = k;
                    sum_at_done  = sum;
                    cout_at_done = cout;
                end
            end
            if (!done && done_k == 0 && sum !== prev_sum) hold_bad = 1'b1;
            if (repulse && k == 3) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end
            if (repulse && k == 5) start = 1'b0;
            tick();
        end
        chk({tag, "_done_cycle"}, done_k, 9);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, 8);
        chk({tag, "_sum"}, 32'(sum_at_done), 32'(es));
        chk({tag, "_cout"}, 32'(cout_at_done), 32'(ec));
        chk({tag, "_sum_held"}, 32'(sum), 32'(es));
        if (check_hold) chk({tag, "_no_partial"}, 32'(hold_bad), 0);
    endtask

    initial begin
        int dcount;
        int prev_k;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum",  32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic add with an ignored re-pulse of start while busy
        do_add("basic", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 8'h00, 1'b1, 1'b1);
        // Result hold: sum stays 0x96 through RUN, then becomes 0x30
        do_add("hold", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h96, 1'b1, 1'b0);

        // Reset in the 4th RUN cycle
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();                 // now in 4th RUN cycle
        chk("mid_busy_before", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_sum",  32'(sum), 0);
        chk("mid_cout", 32'(cout), 0);
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dcount++;
            tick();
        end
        chk("mid_no_done", dcount, 0);
        do_add("fresh", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0);

        // Full carry ripple
        do_add("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 1'b0);
        do_add("ripple2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);

        // Back-to-back with start held high: done every 10 clocks
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        tick();
        dcount = 0;
        prev_k = -1;
        for (int k = 1; k <= 35; k++) begin
            if (done) begin
                dcount++;
                chk("b2b_sum",  32'(sum), 0);
                chk("b2b_cout", 32'(cout), 1);
                if (prev_k >= 0) chk("b2b_spacing", k - prev_k, 10);
                prev_k = k;
            end
            tick();
        end
        start = 1'b0;
        chk("b2b_count", dcount, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
